ysyx_23060332_wbu: RTL and testbench
====================================

Name: ysyx_23060332_wbu

Overview:
Write-back unit between the execute stage and the register file write port (waddr/wdata/reg_wen). Accepts one retiring instruction at a time from EXU over a valid/ready handshake. Non-load results go straight to write-back. Loads issue a word read to data memory, wait for the response, extract and extend the addressed byte, half or word, then write the regfile.

Parameters:
XLEN, 32, datapath width and memory address/data width
REG_AW, 5, register address width

Ports:
clk  input  1  clock
rst  input  1  reset
in_valid  input  1  EXU has an instruction to retire
in_ready  output  1  WBU can accept
in_is_load  input  1  instruction is a load
in_funct3  input  3  load size/sign code (ignored for non-loads)
in_rd  input  REG_AW  destination register
in_rd_wen  input  1  instruction writes rd
in_result  input  XLEN  ALU result, or effective address for loads
mem_req_valid  output  1  read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  XLEN  word-aligned read address
mem_rsp_valid  input  1  read data valid
mem_rsp_data  input  XLEN  read word
reg_wen  output  1  regfile write enable
reg_waddr  output  REG_AW  regfile write address
reg_wdata  output  XLEN  regfile write data
wb_done  output  1  one-cycle pulse per retired instruction
busy  output  1  state != IDLE

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. While rst is high: state=IDLE, all capture registers=0, every output=0, including in_ready.
- Reset mid-operation: in-flight instruction dropped. mem_req_valid low from the next cycle. A late mem_rsp_valid is ignored.
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE: in_ready=1. On in_valid&in_ready, capture is_load, funct3, rd, rd_wen, result. Go to REQ if is_load, else WB.
- REQ: mem_req_valid=1, mem_req_addr={result[XLEN-1:2],2'b00}. Both held stable until mem_req_ready. Then go to WAIT.
- WAIT: on mem_rsp_valid, register the extracted load value into the result register and go to WB. No timeout.
- Response timing: mem_rsp_valid counts only in WAIT, i.e. at the earliest the cycle after request acceptance. It is ignored in IDLE, REQ and WB.
- WB (exactly one cycle): reg_wen = rd_wen && (rd != 0); reg_waddr=rd; reg_wdata=result; wb_done=1. Then go to IDLE.
- reg_waddr and reg_wdata are 0 outside WB.
- rd==0: reg_wen stays 0, but wb_done still pulses.
- Latency, non-load accepted at cycle t: write in cycle t+1, next accept at t+2. Throughput is one instruction per 2 cycles.
- Latency, load: 1 accept + REQ cycles (>=1) + WAIT cycles (>=1) + 1 WB cycle.
- in_ready=0 in REQ, WAIT and WB. No new accept in the same cycle as WB.
- Load extraction, with off=result[1:0]:
  - 000 LB: byte off, sign-extended.
  - 100 LBU: byte off, zero-extended.
  - 001 LH: half off[1], sign-extended.
  - 101 LHU: half off[1], zero-extended.
  - 010 LW: full word.
  - 011/110/111: wdata=0, write still performed.
- Misaligned load (LH/LHU with off[0]=1, LW with off!=0), macro absent: low address bits are dropped as described above; no error indication.

Optional Feature:
Macro WBU_MISALIGN_TRAP_EN.
- Defined: adds output port misalign (1 bit, reset 0). A misaligned load is detected at accept, skips REQ/WAIT and goes directly to WB. In WB: reg_wen=0, wb_done=1, misalign=1 for that single cycle.
- Undefined: port absent; misaligned loads behave as described under Behaviour.

Test Plan:
- Non-load in_result=0x12345678, rd=5, rd_wen=1, accepted cycle t -> cycle t+1: reg_wen=1, reg_waddr=5, reg_wdata=0x12345678, wb_done=1; cycle t+2: in_ready=1.
- LB addr 0x80000003, mem_rsp_data=0x80FF7F01 -> mem_req_addr=0x80000000, reg_wdata=0xFFFFFF80. Same with LBU -> 0x00000080.
- LH addr 0x80000002, rsp=0x8001_1234 -> reg_wdata=0xFFFF8001. LHU -> 0x00008001. LW addr 0x80000000 -> 0x80011234.
- mem_req_ready held low 3 cycles, then rsp delayed 2 cycles; stray mem_rsp_valid pulse during REQ -> request held stable, stray pulse ignored, exactly one write and one wb_done.
- Non-load with rd=0, rd_wen=1 -> reg_wen=0, wb_done=1. rst asserted in WAIT -> next cycle state IDLE, all outputs 0; later mem_rsp_valid causes no write.
- With WBU_MISALIGN_TRAP_EN: LW at 0x80000002 -> no mem_req_valid, next cycle misalign=1, wb_done=1, reg_wen=0.

Source files
------------

// File: rtl/ysyx_23060332_wbu_if.sv
// Write-back unit bus: EXU retire handshake, data-memory read port, regfile write port.
// Optional WBU_MISALIGN_TRAP_EN adds the misalign flag.
interface ysyx_23060332_wbu_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_is_load;
  logic [2:0]        in_funct3;
  logic [REG_AW-1:0] in_rd;
  logic              in_rd_wen;
  logic [XLEN-1:0]   in_result;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_data;
  logic              reg_wen;
  logic [REG_AW-1:0] reg_waddr;
  logic [XLEN-1:0]   reg_wdata;
  logic              wb_done;
  logic              busy;
`ifdef WBU_MISALIGN_TRAP_EN
  logic              misalign;
`endif

  // WBU side
  modport slave (
    input  in_valid, in_is_load, in_funct3, in_rd, in_rd_wen, in_result,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output in_ready, mem_req_valid, mem_req_addr,
    output reg_wen, reg_waddr, reg_wdata, wb_done, busy
`ifdef WBU_MISALIGN_TRAP_EN
    , output misalign
`endif
  );

  // EXU / memory / regfile side
  modport master (
    output in_valid, in_is_load, in_funct3, in_rd, in_rd_wen, in_result,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  in_ready, mem_req_valid, mem_req_addr,
    input  reg_wen, reg_waddr, reg_wdata, wb_done, busy
`ifdef WBU_MISALIGN_TRAP_EN
    , input misalign
`endif
  );
endinterface

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: retires one EXU instruction at a time, performing the load read and
// byte/half/word extraction before the regfile write. Optional macro: WBU_MISALIGN_TRAP_EN.
module ysyx_23060332_wbu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_23060332_wbu_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t            state;
  logic              is_load_q;
  logic [2:0]        funct3_q;
  logic [REG_AW-1:0] rd_q;
  logic              rd_wen_q;
  logic [XLEN-1:0]   result_q;

  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [XLEN-1:0]   load_val_c;
  logic              take_mem_c;
  logic              mis_c;

  // Misaligned-load detection only matters when the trap is built in
`ifdef WBU_MISALIGN_TRAP_EN
  always_comb begin
    mis_c = bus.in_is_load &&
            (((bus.in_funct3[1:0] == 2'b01) && bus.in_result[0]) ||
             ((bus.in_funct3 == 3'b010) && (bus.in_result[1:0] != 2'b00)));
  end
`else
  assign mis_c = 1'b0;
`endif

  assign take_mem_c = bus.in_is_load && !mis_c;

  // Load value extraction from the returned word using the captured address offset
  always_comb begin
    byte_c     = 8'h00;
    half_c     = result_q[1] ? bus.mem_rsp_data[31:16] : bus.mem_rsp_data[15:0];
    load_val_c = '0;
    case (result_q[1:0])
      2'b00:   byte_c = bus.mem_rsp_data[7:0];
      2'b01:   byte_c = bus.mem_rsp_data[15:8];
      2'b10:   byte_c = bus.mem_rsp_data[23:16];
      default: byte_c = bus.mem_rsp_data[31:24];
    endcase
    case (funct3_q)
      3'b000:  load_val_c = {{(XLEN-8){byte_c[7]}}, byte_c};
      3'b100:  load_val_c = {{(XLEN-8){1'b0}}, byte_c};
      3'b001:  load_val_c = {{(XLEN-16){half_c[15]}}, half_c};
      3'b101:  load_val_c = {{(XLEN-16){1'b0}}, half_c};
      3'b010:  load_val_c = bus.mem_rsp_data;
      default: load_val_c = '0;
    endcase
  end

  // FSM with registered outputs; outputs are loaded on the transition into each state
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      is_load_q         <= 1'b0;
      funct3_q          <= 3'b000;
      rd_q              <= '0;
      rd_wen_q          <= 1'b0;
      result_q          <= '0;
      bus.in_ready      <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.reg_wen       <= 1'b0;
      bus.reg_waddr     <= '0;
      bus.reg_wdata     <= '0;
      bus.wb_done       <= 1'b0;
      bus.busy          <= 1'b0;
`ifdef WBU_MISALIGN_TRAP_EN
      bus.misalign      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            is_load_q    <= bus.in_is_load;
            funct3_q     <= bus.in_funct3;
            rd_q         <= bus.in_rd;
            rd_wen_q     <= bus.in_rd_wen;
            result_q     <= bus.in_result;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            if (take_mem_c) begin
              state             <= REQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_req_addr  <= {bus.in_result[XLEN-1:2], 2'b00};
            end else begin
              state         <= WB;
              bus.reg_wen   <= bus.in_rd_wen && (bus.in_rd != '0) && !mis_c;
              bus.reg_waddr <= bus.in_rd;
              bus.reg_wdata <= bus.in_result;
              bus.wb_done   <= 1'b1;
`ifdef WBU_MISALIGN_TRAP_EN
              bus.misalign  <= mis_c;
`endif
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state             <= WAIT;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
          end else begin
            bus.mem_req_addr  <= {result_q[XLEN-1:2], 2'b00};
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid && is_load_q) begin
            state         <= WB;
            result_q      <= load_val_c;
            bus.reg_wen   <= rd_wen_q && (rd_q != '0);
            bus.reg_waddr <= rd_q;
            bus.reg_wdata <= load_val_c;
            bus.wb_done   <= 1'b1;
          end
        end
        WB: begin
          state         <= IDLE;
          bus.reg_wen   <= 1'b0;
          bus.reg_waddr <= '0;
          bus.reg_wdata <= '0;
          bus.wb_done   <= 1'b0;
          bus.busy      <= 1'b0;
          bus.in_ready  <= 1'b1;
`ifdef WBU_MISALIGN_TRAP_EN
          bus.misalign  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Scoreboard bench for ysyx_23060332_wbu: directed stimulus queues expected writes and
// request addresses; a negedge monitor pops and compares them.
module tb_ysyx_23060332_wbu;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   wb_cnt = 0;

  wb_t         exp_q[$];
  logic [31:0] req_q[$];

  ysyx_23060332_wbu_if #(.XLEN(32), .REG_AW(5)) bus ();

  ysyx_23060332_wbu #(.XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted request and every write-back against the queues
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: addr %h with empty queue", bus.mem_req_addr);
          end else begin
            chk("req_addr", bus.mem_req_addr, req_q.pop_front());
          end
        end
        if (bus.wb_done) begin
          wb_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wb: waddr %0d wdata %h", bus.reg_waddr, bus.reg_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("wb_wen",   32'(bus.reg_wen),   32'(e.wen));
            chk("wb_waddr", 32'(bus.reg_waddr), 32'(e.waddr));
            chk("wb_wdata", bus.reg_wdata,      e.wdata);
          end
        end else begin
          chk("idle_wen",   32'(bus.reg_wen),   32'd0);
          chk("idle_wdata", bus.reg_wdata,      32'd0);
        end
      end
    end
  end

  // Present one instruction and hold it until the accepting edge; returns at edge+1
  task automatic issue(input logic is_load, input logic [2:0] f3, input logic [4:0] rd,
                       input logic wen, input logic [31:0] res);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: in_ready stuck at 0");
      return;
    end
    bus.in_valid   = 1'b1;
    bus.in_is_load = is_load;
    bus.in_funct3  = f3;
    bus.in_rd      = rd;
    bus.in_rd_wen  = wen;
    bus.in_result  = res;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
  endtask

  task automatic nonload(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                         input logic exp_wen);
    exp_q.push_back('{exp_wen, rd, res});
    issue(1'b0, 3'b000, rd, wen, res);
    chk("nl_wb_done_t1", 32'(bus.wb_done),  32'd1);
    chk("nl_in_ready_t1", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("nl_in_ready_t2", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic load(input logic [2:0] f3, input logic [4:0] rd, input logic wen,
                      input logic [31:0] addr, input logic [31:0] rsp,
                      input int req_wait, input int rsp_wait, input logic stray,
                      input logic [31:0] exp_data);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    req_q.push_back(waddr);
    exp_q.push_back('{wen && (rd != 5'd0), rd, exp_data});
    issue(1'b1, f3, rd, wen, addr);
    for (int i = 0; i < req_wait; i++) begin
      chk("req_valid_hold", 32'(bus.mem_req_valid), 32'd1);
      chk("req_addr_hold",  bus.mem_req_addr,       waddr);
      bus.mem_rsp_valid = stray && (i == 0);
      bus.mem_rsp_data  = 32'h5A5A_5A5A;
      @(posedge clk); #1;
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    chk("req_dropped", 32'(bus.mem_req_valid), 32'd0);
    for (int j = 0; j < rsp_wait; j++) begin
      chk("wait_no_wb", 32'(bus.wb_done), 32'd0);
      @(posedge clk); #1;
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = rsp;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    chk("ld_wb_done", 32'(bus.wb_done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    rst               = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_is_load    = 1'b0;
    bus.in_funct3     = 3'b000;
    bus.in_rd         = 5'd0;
    bus.in_rd_wen     = 1'b0;
    bus.in_result     = 32'd0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),      32'd0);
    chk("rst_busy",      32'(bus.busy),          32'd0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_wb_done",   32'(bus.wb_done),       32'd0);
    chk("rst_waddr",     32'(bus.reg_waddr),     32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    nonload(5'd5, 1'b1, 32'h1234_5678, 1'b1);
    nonload(5'd7, 1'b1, 32'hDEAD_BEEF, 1'b1);
    nonload(5'd0, 1'b1, 32'h0000_00AA, 1'b0);
    nonload(5'd9, 1'b0, 32'h0000_0055, 1'b0);

    load(3'b000, 5'd1, 1'b1, 32'h8000_0003, 32'h80FF_7F01, 0, 0, 1'b0, 32'hFFFF_FF80);
    load(3'b100, 5'd2, 1'b1, 32'h8000_0003, 32'h80FF_7F01, 0, 0, 1'b0, 32'h0000_0080);
    load(3'b000, 5'd3, 1'b1, 32'h8000_0001, 32'h80FF_7F01, 1, 1, 1'b0, 32'h0000_007F);
    load(3'b001, 5'd4, 1'b1, 32'h8000_0002, 32'h8001_1234, 0, 0, 1'b0, 32'hFFFF_8001);
    load(3'b101, 5'd6, 1'b1, 32'h8000_0002, 32'h8001_1234, 0, 0, 1'b0, 32'h0000_8001);
    load(3'b010, 5'd8, 1'b1, 32'h8000_0000, 32'h8001_1234, 0, 0, 1'b0, 32'h8001_1234);
    load(3'b011, 5'd10, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'h0000_0000);
    load(3'b010, 5'd11, 1'b0, 32'h8000_0008, 32'h1111_2222, 0, 0, 1'b0, 32'h1111_2222);

    snap = wb_cnt;
    load(3'b010, 5'd12, 1'b1, 32'h1000_0004, 32'hCAFE_F00D, 3, 2, 1'b1, 32'hCAFE_F00D);
    chk("stall_one_write", 32'(wb_cnt - snap), 32'd1);

`ifdef WBU_MISALIGN_TRAP_EN
    exp_q.push_back('{1'b0, 5'd13, 32'h8000_0002});
    issue(1'b1, 3'b010, 5'd13, 1'b1, 32'h8000_0002);
    chk("mis_no_req",  32'(bus.mem_req_valid), 32'd0);
    chk("mis_flag",    32'(bus.misalign),      32'd1);
    chk("mis_wb_done", 32'(bus.wb_done),       32'd1);
    @(posedge clk); #1;
    chk("mis_flag_clr", 32'(bus.misalign), 32'd0);
    exp_q.push_back('{1'b0, 5'd14, 32'h8000_0001});
    issue(1'b1, 3'b101, 5'd14, 1'b1, 32'h8000_0001);
    chk("mis_h_flag", 32'(bus.misalign), 32'd1);
    @(posedge clk); #1;
`else
    load(3'b010, 5'd13, 1'b1, 32'h8000_0002, 32'hA5A5_1234, 0, 0, 1'b0, 32'hA5A5_1234);
    load(3'b001, 5'd14, 1'b1, 32'h8000_0001, 32'hA5A5_9234, 0, 0, 1'b0, 32'hFFFF_9234);
`endif

    // Reset while waiting for the response: instruction dropped, late response ignored
    req_q.push_back(32'h2000_0000);
    issue(1'b1, 3'b010, 5'd15, 1'b1, 32'h2000_0000);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy",      32'(bus.busy),          32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),      32'd0);
    chk("mid_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("mid_rst_wb_done",   32'(bus.wb_done),       32'd0);
    rst  = 1'b0;
    snap = wb_cnt;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h7777_7777;
    repeat (2) @(posedge clk);
    #1;
    bus.mem_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("late_rsp_no_wb", 32'(wb_cnt - snap), 32'd0);
    chk("post_rst_ready", 32'(bus.in_ready),  32'd1);

    nonload(5'd31, 1'b1, 32'h0BAD_F00D, 1'b1);

    repeat (2) @(posedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
